variable_rate_fifo: RTL and testbench
=====================================

Name: variable_rate_fifo

Overview:
Parametrised circular-buffer FIFO with multi-lane write and read ports. Each cycle it can accept 0..PAR_WRITE words and release 0..PAR_READ words, with the count chosen per transfer. Exact occupancy tracking, valid/ready handshakes, programmable almost-full/almost-empty flags and a synchronous flush. It is the next-generation replacement for the fixed-step parallel FIFO datapath and sits between producer and consumer stages of differing lane widths.

Parameters:
DATA_WIDTH, 8, bits per word
SIZE, 16, buffer depth in words; power of two, >= 2*max(PAR_WRITE,PAR_READ)
PAR_WRITE, 4, number of write lanes
PAR_READ, 4, number of read lanes
ALMOST_FULL, 12, almost_full asserted when occupancy >= this value
ALMOST_EMPTY, 2, almost_empty asserted when occupancy <= this value

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents; priority below rst
data_in  input  DATA_WIDTH x [0:PAR_WRITE-1]  write lanes; lane 0 is the oldest word
write_valid  input  1  write request
write_count  input  $clog2(PAR_WRITE+1)  words offered on lanes 0..write_count-1
write_ready  output  1  write request is accepted this cycle
data_out  output  DATA_WIDTH x [0:PAR_READ-1]  read lanes; lane 0 is the head of the FIFO
avail_count  output  $clog2(PAR_READ+1)  valid lanes on data_out = min(occupancy, PAR_READ)
read_enable  input  1  read request
read_count  input  $clog2(PAR_READ+1)  words to pop
read_ready  output  1  read request is accepted this cycle
occupancy  output  $clog2(SIZE)+1  words stored
full  output  1  free slots < PAR_WRITE
empty  output  1  occupancy == 0
almost_full  output  1  occupancy >= ALMOST_FULL
almost_empty  output  1  occupancy <= ALMOST_EMPTY

Behaviour:
- State: wptr and rptr, each $clog2(SIZE) bits and wrapping modulo SIZE; occ register, $clog2(SIZE)+1 bits; memory array (not reset).
- rst: wptr=rptr=occ=0. Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0, avail_count=0, data_out all zero.
- free = SIZE - occ, computed from start-of-cycle state.
- write_ready = (write_count <= free); combinational and independent of write_valid and of any same-cycle read. There is no read-credit bypass.
- read_ready = (read_count <= occ); start-of-cycle state. There is no write-to-read bypass.
- Write fire = write_valid & write_ready. On fire, mem[(wptr+i) mod SIZE] <= data_in[i] for i < write_count, and wptr += write_count.
- Read fire = read_enable & read_ready. On fire, rptr += read_count.
- The two transactions are all-or-nothing: no partial acceptance.
- A count of 0 with valid/enable asserted is a no-op that reports ready=1.
- occ_next = occ + (write fire ? write_count : 0) - (read fire ? read_count : 0). Simultaneous write and read are both applied in the same cycle.
- data_out[i] = mem[(rptr+i) mod SIZE] when i < avail_count, else 0. This path is combinational from registered state (zero read latency). Written data becomes visible one cycle after the write fires.
- full, empty, almost_full, almost_empty and occupancy are decoded combinationally from occ only.
- flush (rst=0): wptr=rptr=occ=0 and any same-cycle write or read is discarded. write_ready and read_ready still reflect pre-flush state but have no effect.
- Wrap-around: a burst spanning the end of the array splits across index SIZE-1 and index 0 without loss or reordering.
- rst or flush mid-operation: the next cycle shows the empty-state outputs. Memory contents are irrelevant because data_out is masked.
- Out-of-range counts (write_count > PAR_WRITE, read_count > PAR_READ) are illegal. The verification bench asserts they never occur.

Test Plan:
- Reset then idle -> empty=1, full=0, occupancy=0, avail_count=0, data_out all 0, write_ready=1, read_ready=0 for read_count=1.
- Write {A0,A1,A2} with write_count=3, then a 1-word write B0 -> occupancy=4; data_out lanes 0..3 = A0,A1,A2,B0; avail_count=4.
- Fill from empty with bursts of 4 until occupancy=16 -> full asserts at occupancy 13; write_ready=0 for write_count=1 at 16; data is unchanged after the rejected write.
- occupancy=2, simultaneous write 4 and read 2 -> both fire; occupancy=4; head = the first of the new words.
- Read 3 at occupancy=2 -> read_ready=0 and nothing changes; then read 2 -> occupancy=0, empty=1.
- Wrap test: wptr=rptr=14, write 4 words W0..W3 -> stored at indices 14,15,0,1; data_out = W0..W3. Then flush -> next cycle occupancy=0 and data_out=0.

Source files
------------

// File: rtl/variable_rate_fifo.sv
// Circular-buffer FIFO with multi-lane write and read ports; per-transfer word
// counts, all-or-nothing handshakes, occupancy flags and synchronous flush.
module variable_rate_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int SIZE         = 16,
  parameter int PAR_WRITE    = 4,
  parameter int PAR_READ     = 4,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            data_in [0:PAR_WRITE-1],
  input  logic                             write_valid,
  input  logic [$clog2(PAR_WRITE+1)-1:0]   write_count,
  output logic                             write_ready,
  output logic [DATA_WIDTH-1:0]            data_out [0:PAR_READ-1],
  output logic [$clog2(PAR_READ+1)-1:0]    avail_count,
  input  logic                             read_enable,
  input  logic [$clog2(PAR_READ+1)-1:0]    read_count,
  output logic                             read_ready,
  output logic [$clog2(SIZE):0]            occupancy,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty
);

  localparam int PW  = $clog2(SIZE);
  localparam int OW  = PW + 1;
  localparam int WCW = $clog2(PAR_WRITE + 1);
  localparam int RCW = $clog2(PAR_READ + 1);

  logic [DATA_WIDTH-1:0] mem [0:SIZE-1];
  logic [PW-1:0]         wptr_reg, wptr_next;
  logic [PW-1:0]         rptr_reg, rptr_next;
  logic [OW-1:0]         occ_reg, occ_next;
  logic [OW-1:0]         free_words;
  logic [OW-1:0]         wr_words;
  logic [OW-1:0]         rd_words;
  logic                  write_fire;
  logic                  read_fire;

  assign free_words  = OW'(SIZE) - occ_reg;
  assign write_ready = (OW'(write_count) <= free_words);
  assign read_ready  = (OW'(read_count) <= occ_reg);
  assign write_fire  = write_valid & write_ready;
  assign read_fire   = read_enable & read_ready;
  assign wr_words    = write_fire ? OW'(write_count) : '0;
  assign rd_words    = read_fire ? OW'(read_count) : '0;

  // Pointers wrap naturally because SIZE is a power of two.
  always_comb begin
    wptr_next = wptr_reg + PW'(wr_words);
    rptr_next = rptr_reg + PW'(rd_words);
    occ_next  = occ_reg + wr_words - rd_words;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      occ_reg  <= '0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      occ_reg  <= occ_next;
    end
  end

  // Storage is never reset; stale words are hidden by the output mask.
  always_ff @(posedge clk) begin
    if (!rst && !flush && write_fire) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        if (i < int'(write_count)) begin
          mem[wptr_reg + PW'(i)] <= data_in[i];
        end
      end
    end
  end

  assign avail_count = (occ_reg >= OW'(PAR_READ)) ? RCW'(PAR_READ) : RCW'(occ_reg);

  for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_rd_lane
    assign data_out[gi] = (RCW'(gi) < avail_count) ? mem[rptr_reg + PW'(gi)] : '0;
  end

  assign occupancy    = occ_reg;
  assign empty        = (occ_reg == '0);
  assign full         = (free_words < OW'(PAR_WRITE));
  assign almost_full  = (occ_reg >= OW'(ALMOST_FULL));
  assign almost_empty = (occ_reg <= OW'(ALMOST_EMPTY));

  logic unused_wcw;
  assign unused_wcw = (WCW == 0);

endmodule

// File: tb/tb_variable_rate_fifo.sv
// Directed bench for variable_rate_fifo: a queue model checked every cycle,
// plus literal expectations pinning key points of the sequence.
module tb_variable_rate_fifo;

  localparam int DW = 8;
  localparam int SZ = 16;
  localparam int PW = 4;
  localparam int PR = 4;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in [0:PW-1];
  logic          write_valid = 1'b0;
  logic [2:0]    write_count = '0;
  logic          write_ready;
  logic [DW-1:0] data_out [0:PR-1];
  logic [2:0]    avail_count;
  logic          read_enable = 1'b0;
  logic [2:0]    read_count = '0;
  logic          read_ready;
  logic [4:0]    occupancy;
  logic          full, empty, almost_full, almost_empty;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] q [$];
  bit            model_ok = 1'b0;

  variable_rate_fifo #(
    .DATA_WIDTH(DW), .SIZE(SZ), .PAR_WRITE(PW), .PAR_READ(PR),
    .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in),
    .write_valid(write_valid), .write_count(write_count), .write_ready(write_ready),
    .data_out(data_out), .avail_count(avail_count),
    .read_enable(read_enable), .read_count(read_count), .read_ready(read_ready),
    .occupancy(occupancy), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Model: a word queue; readiness judged on start-of-cycle contents.
  always @(posedge clk) begin
    int sz;
    bit wf, rf;
    sz = q.size();
    if (rst || flush) begin
      q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      wf = write_valid && (int'(write_count) <= SZ - sz);
      rf = read_enable && (int'(read_count) <= sz);
      if (rf) repeat (int'(read_count)) void'(q.pop_front());
      if (wf) for (int i = 0; i < int'(write_count); i++) q.push_back(data_in[i]);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int sz;
    assert (write_count <= PW) else $error("illegal write_count %0d", write_count);
    assert (read_count <= PR) else $error("illegal read_count %0d", read_count);
    if (model_ok) begin
      sz = q.size();
      chk("occupancy", int'(occupancy), sz);
      chk("empty", int'(empty), int'(sz == 0));
      chk("full", int'(full), int'(SZ - sz < PW));
      chk("almost_full", int'(almost_full), int'(sz >= AF));
      chk("almost_empty", int'(almost_empty), int'(sz <= AE));
      chk("avail_count", int'(avail_count), (sz < PR) ? sz : PR);
      chk("write_ready", int'(write_ready), int'(int'(write_count) <= SZ - sz));
      chk("read_ready", int'(read_ready), int'(int'(read_count) <= sz));
      for (int i = 0; i < PR; i++)
        chk($sformatf("data_out[%0d]", i), int'(data_out[i]), (i < sz) ? int'(q[i]) : 0);
    end
  end

  task automatic idle();
    write_valid = 1'b0; write_count = '0;
    read_enable = 1'b0; read_count = '0;
    flush = 1'b0;
    for (int i = 0; i < PW; i++) data_in[i] = '0;
  endtask

  // One clock of traffic; lane i carries base+i.
  task automatic xfer(input bit wv, input int wc, input logic [DW-1:0] base,
                      input bit re, input int rc, input bit fl);
    write_valid = wv; write_count = 3'(wc);
    read_enable = re; read_count = 3'(rc);
    flush = fl;
    for (int i = 0; i < PW; i++) data_in[i] = base + DW'(i);
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // Reset state
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst occupancy", int'(occupancy), 0);
    chk("rst avail", int'(avail_count), 0);
    chk("rst almost_empty", int'(almost_empty), 1);
    chk("rst almost_full", int'(almost_full), 0);
    for (int i = 0; i < PR; i++) chk("rst data_out", int'(data_out[i]), 0);
    write_count = 3'd1; read_count = 3'd1; #1;
    chk("rst write_ready", int'(write_ready), 1);
    chk("rst read_ready", int'(read_ready), 0);
    idle(); #1;

    // Three-word then one-word write
    xfer(1, 3, 8'hA0, 0, 0, 0);
    chk("wr3 visible", int'(data_out[0]), 8'hA0);
    xfer(1, 1, 8'hB0, 0, 0, 0);
    chk("wr4 occupancy", int'(occupancy), 4);
    chk("wr4 avail", int'(avail_count), 4);
    chk("wr4 lane0", int'(data_out[0]), 8'hA0);
    chk("wr4 lane1", int'(data_out[1]), 8'hA1);
    chk("wr4 lane2", int'(data_out[2]), 8'hA2);
    chk("wr4 lane3", int'(data_out[3]), 8'hB0);

    // Zero-count requests are accepted no-ops
    xfer(1, 0, 8'hEE, 1, 0, 0);
    chk("zero-count occupancy", int'(occupancy), 4);
    xfer(0, 0, 8'h00, 1, 4, 0);
    chk("drain empty", int'(empty), 1);

    // Fill to 16: full first appears at 13
    xfer(1, 4, 8'h10, 0, 0, 0);
    xfer(1, 4, 8'h14, 0, 0, 0);
    xfer(1, 4, 8'h18, 0, 0, 0);
    chk("occ12 full", int'(full), 0);
    chk("occ12 almost_full", int'(almost_full), 1);
    xfer(1, 1, 8'h1C, 0, 0, 0);
    chk("occ13 full", int'(full), 1);
    xfer(1, 3, 8'h1D, 0, 0, 0);
    chk("occ16 occupancy", int'(occupancy), 16);
    write_count = 3'd1; #1;
    chk("occ16 write_ready", int'(write_ready), 0);
    idle(); #1;
    xfer(1, 1, 8'hEE, 0, 0, 0);
    chk("rejected write occupancy", int'(occupancy), 16);
    chk("rejected write head", int'(data_out[0]), 8'h10);

    // Drain to 2, then concurrent write 4 / read 2
    xfer(0, 0, 8'h00, 1, 4, 0);
    xfer(0, 0, 8'h00, 1, 4, 0);
    xfer(0, 0, 8'h00, 1, 4, 0);
    xfer(0, 0, 8'h00, 1, 2, 0);
    chk("occ2 head", int'(data_out[0]), 8'h1E);
    xfer(1, 4, 8'h30, 1, 2, 0);
    chk("rw occupancy", int'(occupancy), 4);
    chk("rw head", int'(data_out[0]), 8'h30);
    chk("rw lane3", int'(data_out[3]), 8'h33);

    // Over-read is refused whole
    xfer(0, 0, 8'h00, 1, 4, 0);
    xfer(1, 2, 8'h40, 0, 0, 0);
    read_count = 3'd3; #1;
    chk("read3 at occ2 ready", int'(read_ready), 0);
    idle(); #1;
    xfer(0, 0, 8'h00, 1, 3, 0);
    chk("refused read occupancy", int'(occupancy), 2);
    xfer(0, 0, 8'h00, 1, 2, 0);
    chk("read2 empty", int'(empty), 1);

    // Pointers now at 10; advance both to 14 and write across the wrap
    xfer(1, 4, 8'h50, 0, 0, 0);
    xfer(0, 0, 8'h00, 1, 4, 0);
    xfer(1, 4, 8'hC0, 0, 0, 0);
    chk("wrap lane0", int'(data_out[0]), 8'hC0);
    chk("wrap lane1", int'(data_out[1]), 8'hC1);
    chk("wrap lane2", int'(data_out[2]), 8'hC2);
    chk("wrap lane3", int'(data_out[3]), 8'hC3);
    xfer(0, 0, 8'h00, 1, 2, 0);
    chk("wrap after read2 head", int'(data_out[0]), 8'hC2);
    xfer(1, 4, 8'hD0, 0, 0, 0);
    chk("wrap refill lane2", int'(data_out[2]), 8'hD0);

    // Flush discards a same-cycle write
    xfer(1, 4, 8'hF0, 1, 1, 1);
    chk("flush occupancy", int'(occupancy), 0);
    chk("flush lane0", int'(data_out[0]), 0);
    chk("flush empty", int'(empty), 1);

    // Reset mid-operation
    xfer(1, 4, 8'h60, 0, 0, 0);
    xfer(1, 3, 8'h64, 0, 0, 0);
    chk("pre-rst occupancy", int'(occupancy), 7);
    rst = 1'b1;
    write_valid = 1'b1; write_count = 3'd4;
    @(posedge clk); #1;
    rst = 1'b0; idle(); #1;
    chk("mid-rst occupancy", int'(occupancy), 0);
    chk("mid-rst avail", int'(avail_count), 0);
    xfer(1, 2, 8'h70, 0, 0, 0);
    chk("post-rst head", int'(data_out[0]), 8'h70);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
